// File: rtl/tinysat_driver.sv
// tinysat_driver: host-side sequencer for the tinysat solver core.
// Takes a CNF instance as 96 literal nibbles and drives the solver pins through
// reset, bank-0 padding, clause load, counter clear and run. It then returns one
// result word per job. Every output comes straight from a register.
//
// Handshakes (lit_*, res_*): a beat transfers on a rising edge where valid and
// ready are both high. A producer holds valid and its payload stable until the
// transfer. lit_ready is high only in LOAD. res_valid is high only in RESULT.
module tinysat_driver #(
  parameter int NUM_BITS         = 6,
  parameter int LOG2_NUM_CLAUSES = 5,
  parameter int RUN_LIMIT        = 2080
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                lit_valid,
  output logic                lit_ready,
  input  logic [3:0]          lit_data,
  output logic                sat_reset,
  output logic                sat_run,
  output logic                sat_load,
  output logic [3:0]          sat_data,
  input  logic [7:0]          sat_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NUM_BITS-1:0] res_x,
  output logic                res_sat,
  output logic                res_timeout,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  localparam int NUM_CLAUSES = 1 << LOG2_NUM_CLAUSES;
  localparam int NUM_NIBBLES = 3 * NUM_CLAUSES;
  localparam int BEAT_W      = $clog2(NUM_NIBBLES + 1);
  localparam int RUN_W       = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SRST   = 3'd1,
    ST_PAD    = 3'd2,
    ST_LOAD   = 3'd3,
    ST_CLR    = 3'd4,
    ST_RUN    = 3'd5,
    ST_RESULT = 3'd6
  } state_e;

  state_e                      state_q, state_d;
  logic [LOG2_NUM_CLAUSES-1:0] phase_cnt_q, phase_cnt_d;
  logic [BEAT_W-1:0]           beat_cnt_q, beat_cnt_d;
  logic [RUN_W-1:0]            run_cnt_q, run_cnt_d;
  logic                        lit_ready_q, lit_ready_d;
  logic                        sat_reset_q, sat_reset_d;
  logic                        sat_run_q, sat_run_d;
  logic                        sat_load_q, sat_load_d;
  logic [3:0]                  sat_data_q, sat_data_d;
  logic                        res_valid_q, res_valid_d;
  logic [NUM_BITS-1:0]         res_x_q, res_x_d;
  logic                        res_sat_q, res_sat_d;
  logic                        res_timeout_q, res_timeout_d;
  logic                        busy_q, busy_d;
  logic                        accept;

  assign accept = lit_valid && lit_ready_q;

  // Next-state and next-output logic. Each output register takes the value that
  // belongs to the state being entered, so the outputs line up with state_q.
  always_comb begin
    state_d       = state_q;
    phase_cnt_d   = phase_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    run_cnt_d     = run_cnt_q;
    lit_ready_d   = 1'b0;
    sat_reset_d   = 1'b0;
    sat_run_d     = 1'b0;
    sat_load_d    = 1'b0;
    sat_data_d    = 4'h0;
    res_valid_d   = res_valid_q;
    res_x_d       = res_x_q;
    res_sat_d     = res_sat_q;
    res_timeout_d = res_timeout_q;
    case (state_q)
      ST_IDLE: begin
        sat_reset_d = 1'b1;
        if (start) begin
          state_d     = ST_SRST;
          phase_cnt_d = '0;
        end
      end
      ST_SRST: begin
        if (phase_cnt_q[0]) begin
          state_d     = ST_PAD;
          phase_cnt_d = '0;
          sat_load_d  = 1'b1;
        end else begin
          sat_reset_d = 1'b1;
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      ST_PAD: begin
        // Zero nibbles fill the solver's bank-0 slots, which the solver does not write.
        if (phase_cnt_q == '1) begin
          state_d     = ST_LOAD;
          beat_cnt_d  = '0;
          lit_ready_d = 1'b1;
        end else begin
          sat_load_d  = 1'b1;
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        sat_load_d = accept;
        sat_data_d = accept ? lit_data : 4'h0;
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
        if (beat_cnt_q == BEAT_W'(NUM_NIBBLES)) begin
          // The last nibble is on the pins this cycle. Clear the solver only after it lands.
          state_d     = ST_CLR;
          sat_reset_d = 1'b1;
        end else begin
          lit_ready_d = !(accept && beat_cnt_q == BEAT_W'(NUM_NIBBLES - 1));
        end
      end
      ST_CLR: begin
        state_d   = ST_RUN;
        run_cnt_d = '0;
        sat_run_d = 1'b1;
      end
      ST_RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (sat_out[7]) begin
          // done takes priority over a limit reached in the same cycle
          state_d       = ST_RESULT;
          res_valid_d   = 1'b1;
          res_x_d       = sat_out[NUM_BITS-1:0];
          res_sat_d     = sat_out[6];
          res_timeout_d = 1'b0;
        end else if (run_cnt_q == RUN_W'(RUN_LIMIT - 1)) begin
          state_d       = ST_RESULT;
          res_valid_d   = 1'b1;
          res_x_d       = '0;
          res_sat_d     = 1'b0;
          res_timeout_d = 1'b1;
        end else begin
          sat_run_d = 1'b1;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          sat_reset_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sat_reset_d = 1'b1;
        res_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and output registers. The reset values match the IDLE outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      phase_cnt_q   <= '0;
      beat_cnt_q    <= '0;
      run_cnt_q     <= '0;
      lit_ready_q   <= 1'b0;
      sat_reset_q   <= 1'b1;
      sat_run_q     <= 1'b0;
      sat_load_q    <= 1'b0;
      sat_data_q    <= 4'h0;
      res_valid_q   <= 1'b0;
      res_x_q       <= '0;
      res_sat_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_cnt_q   <= phase_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      run_cnt_q     <= run_cnt_d;
      lit_ready_q   <= lit_ready_d;
      sat_reset_q   <= sat_reset_d;
      sat_run_q     <= sat_run_d;
      sat_load_q    <= sat_load_d;
      sat_data_q    <= sat_data_d;
      res_valid_q   <= res_valid_d;
      res_x_q       <= res_x_d;
      res_sat_q     <= res_sat_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign lit_ready   = lit_ready_q;
  assign sat_reset   = sat_reset_q;
  assign sat_run     = sat_run_q;
  assign sat_load    = sat_load_q;
  assign sat_data    = sat_data_q;
  assign res_valid   = res_valid_q;
  assign res_x       = res_x_q;
  assign res_sat     = res_sat_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule
